// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encodings (3 is illegal and recovers to IDLE) and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_fa_bit.sv
// One-bit full adder built from two half adders and an OR; purely combinational.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
  half_adder u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s),  .o_c(w_c1));

  // Both half-adder carries can never be high together, so OR gives the majority.
  assign o_c = w_c0 | w_c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fa_bit cell, LSB-first shift registers and an IDLE/RUN/DONE FSM.
// Defining SERIAL_ADDER_SUB_EN adds a sub input that turns the operation into a - b.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic             w_sub;
  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_b_load;
  logic [WIDTH-1:0] w_part_nxt;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
  assign w_b_load = w_sub ? ~bus.b : bus.b;
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));

  fa_bit u_fa (
    .i_a (r_a_sr[0]),
    .i_b (r_b_sr[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  generate
    if (WIDTH == 1) begin : g_part_w1
      assign w_part_nxt = w_s;
    end else begin : g_part_wn
      assign w_part_nxt = {w_s, r_part[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_state_nxt = w_last ? ST_DONE : ST_RUN;
      ST_DONE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_RUN:  w_busy = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath; sum/cout only move on the RUN->DONE edge so they hold across later operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= bus.a;
      r_b_sr  <= w_b_load;
      r_part  <= '0;
      r_carry <= w_sub;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_part  <= w_part_nxt;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_part_nxt;
        r_cout <= w_c;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against an arithmetic reference model.
// Subtraction cases are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0] last_sum;
  logic         last_cout;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub);
    bus.a = op_a;
    bus.b = op_b;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = op_sub;
`endif
  endtask

  // Reference: plain integer add, or modular difference with "no borrow" flag.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] es, output logic ec);
    int unsigned t;
    if (s) begin
      t  = (int'(x) - int'(y)) & ((1 << W) - 1);
      es = t[W-1:0];
      ec = (x >= y);
    end else begin
      t  = int'(x) + int'(y);
      es = t[W-1:0];
      ec = t[W];
    end
  endtask

  // Launch one operation; inj >= 0 raises a spurious start in that RUN cycle.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_sub, input int inj);
    logic [W-1:0] es;
    logic         ec;
    model(op_a, op_b, op_sub, es, ec);
    bus.start = 1'b1;
    set_ops(op_a, op_b, op_sub);
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check_val("busy_run", bus.busy, 1);
      check_val("done_run", bus.done, 0);
      check_val("sum_hold", bus.sum, last_sum);
      check_val("cout_hold", bus.cout, last_cout);
      if (i == inj) begin
        bus.start = 1'b1;
        set_ops(8'hAA, 8'h55, 1'b0);
      end else begin
        bus.start = 1'b0;
      end
      tick;
    end
    bus.start = 1'b0;
    check_val("done", bus.done, 1);
    check_val("busy_done", bus.busy, 0);
    check_val("sum", bus.sum, es);
    check_val("cout", bus.cout, ec);
    last_sum  = es;
    last_cout = ec;
    tick;
    check_val("done_pulse", bus.done, 0);
    check_val("busy_idle", bus.busy, 0);
    check_val("sum_idle", bus.sum, last_sum);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           rinj;
    int           gap;

    rst       = 1'b1;
    bus.start = 1'b0;
    set_ops('0, '0, 1'b0);
    last_sum  = '0;
    last_cout = 1'b0;
    #2;
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_sum", bus.sum, 0);
    check_val("rst_cout", bus.cout, 0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check_val("idle_busy", bus.busy, 0);
    check_val("idle_done", bus.done, 0);

    run_op(8'h0F, 8'h01, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b0, -1);
    run_op(8'hFF, 8'hFF, 1'b0, -1);
    run_op(8'h03, 8'h04, 1'b0, 2);

    // Reset in RUN cycle 4 must clear everything immediately.
    bus.start = 1'b1;
    set_ops(8'h5A, 8'h33, 1'b0);
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    tick;
    check_val("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_val("midrst_busy", bus.busy, 0);
    check_val("midrst_done", bus.done, 0);
    check_val("midrst_sum", bus.sum, 0);
    check_val("midrst_cout", bus.cout, 0);
    last_sum  = '0;
    last_cout = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    run_op(8'h12, 8'h34, 1'b0, -1);

    // start held high: each DONE relaunches straight into RUN.
    bus.start = 1'b1;
    set_ops(8'h01, 8'h01, 1'b0);
    tick;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W; i++) begin
        check_val("b2b_busy", bus.busy, 1);
        check_val("b2b_done_run", bus.done, 0);
        tick;
      end
      check_val("b2b_done", bus.done, 1);
      check_val("b2b_busy_done", bus.busy, 0);
      check_val("b2b_sum", bus.sum, 8'h02);
      check_val("b2b_cout", bus.cout, 0);
      if (k == 2) bus.start = 1'b0;
      tick;
    end
    check_val("b2b_end_busy", bus.busy, 0);
    check_val("b2b_end_done", bus.done, 0);
    last_sum  = 8'h02;
    last_cout = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, -1);
    run_op(8'h07, 8'h05, 1'b1, -1);
    run_op(8'h3C, 8'h3C, 1'b1, -1);
    run_op(8'h11, 8'h22, 1'b0, -1);
`endif

    for (int n = 0; n < 40; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs   = 1'($urandom_range(0, 1));
`else
      rs   = 1'b0;
`endif
      rinj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_op(ra, rb, rs, rinj);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick;
        check_val("gap_busy", bus.busy, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
